// File: rtl/axis64_to_fifo72.sv
// Frames 64-bit MAC beats into 72-bit XGMII words for the transmit FIFO:
// start word, data, terminate, then IFG_WORDS idle words per frame.
module axis64_to_fifo72 #(
    parameter int IFG_WORDS = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [63:0] s_data,
    input  logic        s_valid,
    input  logic        s_last,
    input  logic [2:0]  s_bytes,
    output logic        s_ready,
    output logic        wr_clk,
    output logic [71:0] din,
    output logic        wr_en,
    input  logic        full,
    output logic [31:0] frame_cnt,
    output logic [15:0] err_cnt,
    output logic [2:0]  dbg_state
);

    // Handshake: a beat moves when s_valid & s_ready are both high at the rising
    // edge; s_ready is combinational from state and full, never from s_valid.

    localparam logic [71:0] WORD_START = 72'h01_d5_55_55_55_55_55_55_fb;
    localparam logic [71:0] WORD_IDLE  = 72'hff_07_07_07_07_07_07_07_07;
    localparam logic [71:0] WORD_TERM  = 72'hff_07_07_07_07_07_07_07_fd;
    localparam logic [71:0] WORD_ERR   = 72'hff_fe_fe_fe_fe_fe_fe_fe_fe;

    localparam int CW = (IFG_WORDS > 1) ? $clog2(IFG_WORDS) : 1;
    localparam logic [CW-1:0] IFG_LOAD = CW'(IFG_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_TERM = 3'd2,
        ST_IFG  = 3'd3,
        ST_DROP = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [71:0]   din_q, din_d;
    logic          wr_en_q, wr_en_d;
    logic [31:0]   frame_cnt_q, frame_cnt_d;
    logic [15:0]   err_cnt_q, err_cnt_d;
    logic [CW-1:0] ifg_cnt_q, ifg_cnt_d;
    logic          s_ready_c;
    logic [71:0]   last_word;

    // Partial last beat: data lanes below s_bytes, terminate in lane s_bytes, idles above.
    always_comb begin
        last_word = '0;
        for (int i = 0; i < 8; i++) begin
            if (3'(i) < s_bytes) begin
                last_word[8*i +: 8] = s_data[8*i +: 8];
                last_word[64 + i]   = 1'b0;
            end else if (3'(i) == s_bytes) begin
                last_word[8*i +: 8] = 8'hfd;
                last_word[64 + i]   = 1'b1;
            end else begin
                last_word[8*i +: 8] = 8'h07;
                last_word[64 + i]   = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        din_d       = din_q;
        wr_en_d     = 1'b0;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        ifg_cnt_d   = ifg_cnt_q;
        s_ready_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s_valid && !full) begin
                    din_d   = WORD_START;
                    wr_en_d = 1'b1;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!full) begin
                    s_ready_c = 1'b1;
                    wr_en_d   = 1'b1;
                    if (!s_valid) begin
                        din_d   = WORD_ERR;
                        state_d = ST_DROP;
                        if (err_cnt_q != 16'hffff) err_cnt_d = err_cnt_q + 16'd1;
                    end else if (s_last && s_bytes != 3'd0) begin
                        din_d       = last_word;
                        frame_cnt_d = frame_cnt_q + 32'd1;
                        ifg_cnt_d   = IFG_LOAD;
                        state_d     = ST_IFG;
                    end else begin
                        din_d = {8'h00, s_data};
                        if (s_last) state_d = ST_TERM;
                    end
                end
            end
            ST_TERM: begin
                if (!full) begin
                    din_d       = WORD_TERM;
                    wr_en_d     = 1'b1;
                    frame_cnt_d = frame_cnt_q + 32'd1;
                    ifg_cnt_d   = IFG_LOAD;
                    state_d     = ST_IFG;
                end
            end
            ST_IFG: begin
                if (!full) begin
                    din_d   = WORD_IDLE;
                    wr_en_d = 1'b1;
                    if (ifg_cnt_q == '0) state_d = ST_IDLE;
                    else ifg_cnt_d = ifg_cnt_q - CW'(1);
                end
            end
            ST_DROP: begin
                // Draining writes nothing, so it keeps consuming even while full.
                s_ready_c = 1'b1;
                if (s_valid && s_last) begin
                    ifg_cnt_d = IFG_LOAD;
                    state_d   = ST_IFG;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            din_q       <= WORD_IDLE;
            wr_en_q     <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            ifg_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            din_q       <= din_d;
            wr_en_q     <= wr_en_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
            ifg_cnt_q   <= ifg_cnt_d;
        end
    end

    assign s_ready   = s_ready_c;
    assign wr_clk    = sys_clk;
    assign din       = din_q;
    assign wr_en     = wr_en_q;
    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_axis64_to_fifo72.sv
// Directed bench for axis64_to_fifo72: captures every FIFO write and compares
// the word stream and counters against hand-computed expectations.
module tb_axis64_to_fifo72;

    localparam logic [71:0] W_START = 72'h01_d5_55_55_55_55_55_55_fb;
    localparam logic [71:0] W_IDLE  = 72'hff_07_07_07_07_07_07_07_07;
    localparam logic [71:0] W_TERM  = 72'hff_07_07_07_07_07_07_07_fd;
    localparam logic [71:0] W_ERR   = 72'hff_fe_fe_fe_fe_fe_fe_fe_fe;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [63:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic [2:0]  s_bytes;
    logic        s_ready;
    logic        wr_clk;
    logic [71:0] din;
    logic        wr_en;
    logic        full;
    logic [31:0] frame_cnt;
    logic [15:0] err_cnt;
    logic [2:0]  dbg_state;

    int total = 0;
    int bad = 0;
    int stall_left = 0;

    logic [71:0] exp_q[$];
    logic [71:0] got_q[$];
    logic [63:0] beat_q[$];

    axis64_to_fifo72 #(.IFG_WORDS(2)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_bytes   (s_bytes),
        .s_ready   (s_ready),
        .wr_clk    (wr_clk),
        .din       (din),
        .wr_en     (wr_en),
        .full      (full),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 sys_clk = ~sys_clk;

    // capture each FIFO write just after the edge that registers it
    always @(posedge sys_clk) begin
        #1;
        if (wr_en === 1'b1) got_q.push_back(din);
    end

    task automatic chk72(input string tag, input logic [71:0] obs, input logic [71:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // driver tasks: every step starts on the falling edge
    task automatic drive_full();
        if (full) chk32("stall_wr_en", {31'd0, wr_en}, 32'd0);
        full = (stall_left > 0);
        if (stall_left > 0) stall_left--;
    endtask

    task automatic idle_cycle();
        @(negedge sys_clk);
        drive_full();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic l, input logic [2:0] b);
        int n = 0;
        logic acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge sys_clk);
            drive_full();
            s_valid = 1'b1;
            s_data  = d;
            s_last  = l;
            s_bytes = b;
            #1;
            if (full) chk32("stall_ready", {31'd0, s_ready}, 32'd0);
            acc = s_ready;
            n++;
        end
        if (!acc) begin
            bad++;
            total++;
            $display("FAIL beat_timeout observed=not_accepted expected=accepted");
        end
    endtask

    task automatic send_frame(input logic [2:0] nb, input int gap_idx, input int stall_idx);
        for (int i = 0; i < beat_q.size(); i++) begin
            if (i == stall_idx) stall_left = 3;
            send_beat(beat_q[i], (i == beat_q.size() - 1), nb);
            if (i == gap_idx) idle_cycle();
        end
        beat_q.delete();
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) idle_cycle();
    endtask

    // scoreboard comparison of captured writes against the expected queue
    task automatic check_words(input string tag);
        int n;
        chk32({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk72($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        sys_rst = 1'b1;
        s_data  = '0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_bytes = '0;
        full    = 1'b0;
        #1;
        chk32("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk72("rst_din", din, W_IDLE);
        chk32("rst_ready", {31'd0, s_ready}, 32'd0);
        chk32("rst_frame_cnt", frame_cnt, 32'd0);
        chk32("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
        chk32("rst_state", {29'd0, dbg_state}, 32'd0);
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        flush(2);
        chk32("idle_no_write", got_q.size(), 32'd0);

        // single-beat frame, full last beat
        beat_q.push_back(64'h0807060504030201);
        send_frame(3'd0, -1, -1);
        flush(8);
        exp_q.push_back(W_START);
        exp_q.push_back(72'h00_0807060504030201);
        exp_q.push_back(W_TERM);
        exp_q.push_back(W_IDLE);
        exp_q.push_back(W_IDLE);
        check_words("single");
        chk32("single_frame_cnt", frame_cnt, 32'd1);

        // two-beat frame, 3 bytes in last beat
        beat_q.push_back(64'h0123456789abcdef);
        beat_q.push_back(64'h1111111111ccbbaa);
        send_frame(3'd3, -1, -1);
        flush(8);
        exp_q.push_back(W_START);
        exp_q.push_back(72'h00_0123456789abcdef);
        exp_q.push_back(72'hf8_07_07_07_07_fd_cc_bb_aa);
        exp_q.push_back(W_IDLE);
        exp_q.push_back(W_IDLE);
        check_words("partial");
        chk32("partial_frame_cnt", frame_cnt, 32'd2);

        // three-cycle full stall in the middle of DATA
        beat_q.push_back(64'hdeadbeef00000001);
        beat_q.push_back(64'hdeadbeef00000002);
        beat_q.push_back(64'hdeadbeef00000003);
        send_frame(3'd0, -1, 1);
        flush(8);
        exp_q.push_back(W_START);
        exp_q.push_back(72'h00_deadbeef00000001);
        exp_q.push_back(72'h00_deadbeef00000002);
        exp_q.push_back(72'h00_deadbeef00000003);
        exp_q.push_back(W_TERM);
        exp_q.push_back(W_IDLE);
        exp_q.push_back(W_IDLE);
        check_words("stall");
        chk32("stall_frame_cnt", frame_cnt, 32'd3);

        // underrun after the first beat, rest of frame drained
        beat_q.push_back(64'haaaaaaaaaaaaaaaa);
        beat_q.push_back(64'hbbbbbbbbbbbbbbbb);
        beat_q.push_back(64'hcccccccccccccccc);
        send_frame(3'd5, 0, -1);
        flush(8);
        exp_q.push_back(W_START);
        exp_q.push_back(72'h00_aaaaaaaaaaaaaaaa);
        exp_q.push_back(W_ERR);
        exp_q.push_back(W_IDLE);
        exp_q.push_back(W_IDLE);
        check_words("underrun");
        chk32("underrun_err_cnt", {16'd0, err_cnt}, 32'd1);
        chk32("underrun_frame_cnt", frame_cnt, 32'd3);

        // back-to-back frames with s_valid held high
        beat_q.push_back(64'h0000000000000001);
        send_frame(3'd0, -1, -1);
        beat_q.push_back(64'hffeeddccbbaa9988);
        send_frame(3'd7, -1, -1);
        flush(8);
        exp_q.push_back(W_START);
        exp_q.push_back(72'h00_0000000000000001);
        exp_q.push_back(W_TERM);
        exp_q.push_back(W_IDLE);
        exp_q.push_back(W_IDLE);
        exp_q.push_back(W_START);
        exp_q.push_back(72'h80_fd_ee_dd_cc_bb_aa_99_88);
        exp_q.push_back(W_IDLE);
        exp_q.push_back(W_IDLE);
        check_words("b2b");
        chk32("b2b_frame_cnt", frame_cnt, 32'd5);

        // asynchronous reset in the middle of DATA
        send_beat(64'h1234567812345678, 1'b0, 3'd0);
        @(negedge sys_clk);
        chk32("pre_rst_wr_en", {31'd0, wr_en}, 32'd1);
        #2;
        sys_rst = 1'b1;
        #1;
        chk32("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk72("mid_rst_din", din, W_IDLE);
        chk32("mid_rst_frame_cnt", frame_cnt, 32'd0);
        chk32("mid_rst_err_cnt", {16'd0, err_cnt}, 32'd0);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        got_q.delete();
        beat_q.push_back(64'h5555555555555555);
        send_frame(3'd0, -1, -1);
        flush(8);
        exp_q.push_back(W_START);
        exp_q.push_back(72'h00_5555555555555555);
        exp_q.push_back(W_TERM);
        exp_q.push_back(W_IDLE);
        exp_q.push_back(W_IDLE);
        check_words("after_rst");
        chk32("after_rst_frame_cnt", frame_cnt, 32'd1);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
